shift_unit_iter: RTL and testbench

Multi-cycle shift/rotate unit for the 54-instruction CPU datapath, the consumer of bit-position counts. It takes a 32-bit operand and a shift amount, which comes either from an instruction's shamt/rs field or directly from the leading-zero count (0..32) for normalization, and applies the shift one bit per clock. Results are delivered with a start/busy/done handshake, so the control FSM can stall on long shifts instead of paying for a 32-bit barrel shifter.

---
 rtl/shift_unit_pkg.sv | 19 +
 rtl/shift_step.sv | 17 +
 rtl/shift_unit_iter.sv | 67 ++++++
 tb/tb_shift_unit_iter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/shift_unit_pkg.sv
// shift_unit_pkg: op encodings, FSM states and count helper for shift_unit_iter
package shift_unit_pkg;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_ROTL = 2'b10;
    localparam logic [1:0] OP_SRA  = 2'b11;

    localparam int MAX_SHIFT = 32;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // Shifts saturate at the word width; rotates wrap modulo the width.
    function automatic logic [5:0] eff_count(input logic [1:0] op, input logic [5:0] amt);
        return (op == OP_ROTL) ? {1'b0, amt[4:0]} :
               (amt > 6'(MAX_SHIFT)) ? 6'(MAX_SHIFT) : amt;
    endfunction

endpackage

// File: rtl/shift_step.sv
// shift_step: combinational single-bit shift/rotate step
module shift_step
    import shift_unit_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] x,
    output logic [31:0] y
);

    always_comb begin
        y = (op == OP_SLL) ? {x[30:0], 1'b0}  :
            (op == OP_SRL) ? {1'b0, x[31:1]}  :
            (op == OP_SRA) ? {x[31], x[31:1]} :
                             {x[30:0], x[31]};
    end

endmodule

// File: rtl/shift_unit_iter.sv
// shift_unit_iter: one-bit-per-clock shift/rotate unit with start/busy/done handshake
module shift_unit_iter
    import shift_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [5:0]       amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r
);

    state_t           state, state_nx;
    logic [5:0]       cnt, n;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] work, step_y;
    logic             accept;

    assign n      = eff_count(op, amt);
    assign accept = start && (state != SHIFT);

    shift_step u_step (
        .op (op_q),
        .x  (work),
        .y  (step_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = IDLE;
        if (state == SHIFT)
            state_nx = (cnt == 6'd1) ? DONE : SHIFT;
        else if (accept)
            state_nx = (n != 6'd0) ? SHIFT : DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work <= '0;
            cnt  <= '0;
            op_q <= OP_SLL;
        end else if (accept) begin
            work <= a;
            cnt  <= n;
            op_q <= op;
        end else if (state == SHIFT) begin
            work <= step_y;
            cnt  <= cnt - 6'd1;
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);
    assign r    = work;

endmodule

// File: tb/tb_shift_unit_iter.sv
// tb_shift_unit_iter: scoreboard bench for shift_unit_iter
module tb_shift_unit_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [5:0]  amt = '0;
    logic        busy, done;
    logic [31:0] r;

    int passed = 0;
    int total = 0;

    typedef struct {
        logic [31:0] r;
        int          lat;
    } exp_t;

    exp_t sb[$];

    shift_unit_iter #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .amt   (amt),
        .busy  (busy),
        .done  (done),
        .r     (r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Independent reference using language shift operators.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [5:0] s);
        exp_t e;
        int   k;
        k = (o == 2'b10) ? int'(s % 32) : ((s > 32) ? 32 : int'(s));
        case (o)
            2'b00:   e.r = (k == 32) ? 32'h0 : x << k;
            2'b01:   e.r = (k == 32) ? 32'h0 : x >> k;
            2'b11:   e.r = (k == 32) ? {32{x[31]}} : 32'($signed(x) >>> k);
            default: e.r = (k == 0) ? x : ((x << k) | (x >> (32 - k)));
        endcase
        e.lat = k + 1;
        return e;
    endfunction

    // Starts in the current cycle (so calls chained right after done test back-to-back accept).
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [5:0] s, input bit stray);
        exp_t e;
        int   lat, busies;
        bit   overlap;
        sb.push_back(model(o, x, s));
        op = o; a = x; amt = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; busies = int'(busy); overlap = busy & done;
        while (!done && lat < 100) begin
            if (stray && lat == 2) begin
                start = 1'b1; op = 2'b01; a = 32'h1; amt = 6'd1;
            end else if (stray && lat == 3) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            busies += int'(busy);
            overlap |= busy & done;
        end
        start = 1'b0;
        e = sb.pop_front();
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        check({tag, " result"}, r, e.r);
        check({tag, " busy cycles"}, 32'(busies), 32'(e.lat - 1));
        check({tag, " busy&done"}, 32'(overlap), 32'd0);
    endtask

    initial begin
        int seen;
        repeat (3) @(posedge clk);
        #1;
        check("reset r", r, 32'h0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("sll4", 2'b00, 32'h00000001, 6'd4, 1'b0);
        run_op("sra40", 2'b11, 32'h80000000, 6'd40, 1'b0);
        run_op("srl40", 2'b01, 32'h80000000, 6'd40, 1'b0);
        run_op("rotl33", 2'b10, 32'h80000001, 6'd33, 1'b0);
        run_op("srl0", 2'b01, 32'h12345678, 6'd0, 1'b0);
        run_op("sll8 stray", 2'b00, 32'hFFFFFFFF, 6'd8, 1'b1);
        run_op("b2b sll1", 2'b00, 32'h00000001, 6'd1, 1'b0);
        run_op("sll32", 2'b00, 32'hFFFFFFFF, 6'd32, 1'b0);
        run_op("sra32 pos", 2'b11, 32'h7FFFFFFF, 6'd32, 1'b0);
        run_op("rotl31", 2'b10, 32'h00000003, 6'd31, 1'b0);
        for (int i = 0; i < 6; i++)
            run_op("rand", 2'($urandom_range(0, 3)), $urandom, 6'($urandom_range(0, 63)), 1'b0);

        // Asynchronous reset mid-shift, applied away from a clock edge
        op = 2'b01; a = 32'hDEADBEEF; amt = 6'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async rst r", r, 32'h0);
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            seen += int'(done) + int'(busy);
        end
        check("no activity after rst", 32'(seen), 32'd0);
        run_op("post rst srl4", 2'b01, 32'hF0000000, 6'd4, 1'b0);
        check("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
